// File: rtl/link_hang_scheduler.sv
// Central scheduler for the per-link hang injectors: grants one hang at a time by
// round-robin, drops every other request, and enforces a start delay and a cooldown.
module link_hang_scheduler #(
    parameter int N_LINKS     = 5,
    parameter int CNT_W       = 16,
    parameter int COOLDOWN    = 32,
    parameter int START_CYCLE = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic [N_LINKS-1:0]       req_i,
    input  logic [N_LINKS*CNT_W-1:0] len_i,
    output logic [N_LINKS-1:0]       grant_o,
    output logic [N_LINKS-1:0]       done_o,
    output logic [N_LINKS-1:0]       drop_o,
    output logic                     busy_o,
    output logic [15:0]              total_o
);
    localparam int PW   = (N_LINKS > 1) ? $clog2(N_LINKS) : 1;
    localparam int CD_W = (COOLDOWN > 1) ? $clog2(COOLDOWN + 1) : 1;

    typedef enum logic [1:0] {S_WAIT, S_IDLE, S_HANG, S_COOL} state_t;

    state_t             r_state;
    logic [PW-1:0]      r_rr;
    logic [31:0]        r_cyc;
    logic [CNT_W-1:0]   r_rem;
    logic [CD_W-1:0]    r_cool;
    logic [N_LINKS-1:0] r_grant;
    logic [N_LINKS-1:0] r_done;
    logic [N_LINKS-1:0] r_drop;
    logic               r_busy;
    logic [15:0]        r_total;

    logic [PW-1:0]      w_win;
    logic [N_LINKS-1:0] w_oh;
    logic [CNT_W-1:0]   w_len;
    logic               w_started;
    logic               w_accept;

    // Scan from farthest to nearest so the last hit is the first set bit after r_rr.
    always_comb begin
        w_win = '0;
        w_oh  = '0;
        w_len = '0;
        for (int k = N_LINKS; k >= 1; k--) begin
            if (req_i[(int'(r_rr) + k) % N_LINKS]) begin
                w_win = PW'((int'(r_rr) + k) % N_LINKS);
                w_oh  = '0;
                w_oh[(int'(r_rr) + k) % N_LINKS] = 1'b1;
                w_len = len_i[((int'(r_rr) + k) % N_LINKS) * CNT_W +: CNT_W];
            end
        end
    end

    // Written as cyc+1 > START so a zero start delay does not fold into a constant compare.
    assign w_started = ({1'b0, r_cyc} + 33'd1) > 33'(START_CYCLE);
    assign w_accept  = enable_i && (|req_i) && (w_len != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_WAIT;
            r_rr    <= PW'(N_LINKS - 1);
            r_cyc   <= '0;
            r_rem   <= '0;
            r_cool  <= '0;
            r_grant <= '0;
            r_done  <= '0;
            r_drop  <= '0;
            r_busy  <= 1'b0;
            r_total <= '0;
        end else begin
            r_cyc  <= (&r_cyc) ? r_cyc : r_cyc + 32'd1;
            r_done <= '0;
            r_drop <= req_i;
            case (r_state)
                S_WAIT: begin
                    if (w_started) r_state <= S_IDLE;
                end
                S_IDLE: begin
                    if (w_accept) begin
                        r_drop  <= req_i & ~w_oh;
                        r_rr    <= w_win;
                        r_rem   <= w_len;
                        r_grant <= w_oh;
                        r_done  <= (w_len == CNT_W'(1)) ? w_oh : '0;
                        r_busy  <= 1'b1;
                        r_total <= (&r_total) ? r_total : r_total + 16'd1;
                        r_state <= S_HANG;
                    end
                end
                S_HANG: begin
                    if (r_rem == CNT_W'(1)) begin
                        r_grant <= '0;
                        if (COOLDOWN == 0) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_cool  <= CD_W'(COOLDOWN);
                            r_state <= S_COOL;
                        end
                    end else if (!enable_i) begin
                        // Abort: collapse to a single final grant cycle.
                        r_rem  <= CNT_W'(1);
                        r_done <= r_grant;
                    end else begin
                        r_rem <= r_rem - CNT_W'(1);
                        if (r_rem == CNT_W'(2)) r_done <= r_grant;
                    end
                end
                S_COOL: begin
                    if (r_cool == CD_W'(1)) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cool <= r_cool - CD_W'(1);
                    end
                end
                default: r_state <= S_WAIT;
            endcase
        end
    end

    assign grant_o = r_grant;
    assign done_o  = r_done;
    assign drop_o  = r_drop;
    assign busy_o  = r_busy;
    assign total_o = r_total;
endmodule

// File: tb/tb_link_hang_scheduler.sv
// Scoreboard bench for link_hang_scheduler: each scenario pushes per-cycle expected
// outputs when it drives a request and compares them as the cycles go by.
module tb_link_hang_scheduler;
    localparam int N     = 5;
    localparam int W     = 16;
    localparam int COOL  = 8;
    localparam int START = 100;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            enable_i;
    logic [N-1:0]    req_i;
    logic [N*W-1:0]  len_i;
    logic [N-1:0]    grant_o, done_o, drop_o;
    logic            busy_o;
    logic [15:0]     total_o;

    link_hang_scheduler #(.N_LINKS(N), .CNT_W(W), .COOLDOWN(COOL), .START_CYCLE(START)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i), .req_i(req_i), .len_i(len_i),
        .grant_o(grant_o), .done_o(done_o), .drop_o(drop_o), .busy_o(busy_o), .total_o(total_o)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or negedge rst_ni)
        if (!rst_ni) cyc <= 0;
        else         cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [N-1:0] g, d, dr;
        logic         b;
        logic [15:0]  t;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_total = 16'd0;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        req_i = '0;
    endtask

    task automatic set_len(input int i, input int v);
        len_i[i*W +: W] = W'(v);
    endtask

    task automatic push_rec(input int c, input logic [N-1:0] g, input logic [N-1:0] d,
                            input logic [N-1:0] dr, input logic b);
        exp_t r;
        r.cyc = c; r.g = g; r.d = d; r.dr = dr; r.b = b; r.t = exp_total;
        sb.push_back(r);
    endtask

    // glen is the number of grant cycles actually expected (shorter than len on abort).
    task automatic push_hang(input int c, input logic [N-1:0] win, input int glen,
                             input logic [N-1:0] drops);
        exp_total = (exp_total == 16'hFFFF) ? exp_total : exp_total + 16'd1;
        for (int k = 1; k <= glen; k++)
            push_rec(c + k, win, (k == glen) ? win : '0, (k == 1) ? drops : '0, 1'b1);
        for (int k = 1; k <= COOL; k++)
            push_rec(c + glen + k, '0, '0, '0, 1'b1);
        push_rec(c + glen + COOL + 1, '0, '0, '0, 1'b0);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; enable_i = 1'b1; req_i = '0; len_i = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (grant_o !== '0) begin n_err++; $display("FAIL reset_grant got=%b exp=0", grant_o); end
        n_cmp++; if (done_o  !== '0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done_o); end
        n_cmp++; if (drop_o  !== '0) begin n_err++; $display("FAIL reset_drop got=%b exp=0", drop_o); end
        n_cmp++; if (busy_o  !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        n_cmp++; if (total_o !== '0) begin n_err++; $display("FAIL reset_total got=%h exp=0", total_o); end
        rst_ni = 1'b1;
    endtask

    task automatic test_start_window();
        int tgt = 50;
        for (int ph = 0; ph < 4; ph++) begin
            while (cyc < tgt) begin
                step();
                while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    e = sb.pop_front(); n_cmp++;
                    if (e.cyc != cyc || grant_o !== e.g || done_o !== e.d || drop_o !== e.dr ||
                        busy_o !== e.b || total_o !== e.t) begin
                        n_err++;
                        $display("FAIL start_window cyc=%0d got g=%b d=%b dr=%b b=%b t=%h exp cyc=%0d g=%b d=%b dr=%b b=%b t=%h",
                                 cyc, grant_o, done_o, drop_o, busy_o, total_o, e.cyc, e.g, e.d, e.dr, e.b, e.t);
                    end
                end
            end
            case (ph)
                0: begin req_i = 5'b00100; set_len(2, 5); push_rec(cyc + 1, '0, '0, 5'b00100, 1'b0); tgt = START; end
                1: begin req_i = 5'b00100; set_len(2, 5); push_rec(cyc + 1, '0, '0, 5'b00100, 1'b0); tgt = START + 1; end
                2: begin req_i = 5'b00100; set_len(2, 4); push_hang(cyc, 5'b00100, 4, '0); tgt = cyc + 4 + COOL + 1; end
                default: ;
            endcase
        end
    endtask

    task automatic test_single_hang();
        int c = cyc;
        req_i = 5'b00010; set_len(1, 10);
        push_hang(c, 5'b00010, 10, '0);
        while (cyc < c + 11 + COOL) begin
            step();
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front(); n_cmp++;
                if (e.cyc != cyc || grant_o !== e.g || done_o !== e.d || drop_o !== e.dr ||
                    busy_o !== e.b || total_o !== e.t) begin
                    n_err++;
                    $display("FAIL single_hang cyc=%0d got g=%b d=%b dr=%b b=%b t=%h exp cyc=%0d g=%b d=%b dr=%b b=%b t=%h",
                             cyc, grant_o, done_o, drop_o, busy_o, total_o, e.cyc, e.g, e.d, e.dr, e.b, e.t);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        int wins [4] = '{4, 0, 2, 4};
        for (int r = 0; r < 4; r++) begin
            int c = cyc;
            logic [N-1:0] w = '0;
            w[wins[r]] = 1'b1;
            req_i = (r == 0) ? 5'b10000 : 5'b10101;
            for (int i = 0; i < N; i++) set_len(i, 3);
            push_hang(c, w, 3, req_i & ~w);
            while (cyc < c + 3 + COOL + 1) begin
                step();
                while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    e = sb.pop_front(); n_cmp++;
                    if (e.cyc != cyc || grant_o !== e.g || done_o !== e.d || drop_o !== e.dr ||
                        busy_o !== e.b || total_o !== e.t) begin
                        n_err++;
                        $display("FAIL round_robin r=%0d cyc=%0d got g=%b d=%b dr=%b b=%b t=%h exp cyc=%0d g=%b d=%b dr=%b b=%b t=%h",
                                 r, cyc, grant_o, done_o, drop_o, busy_o, total_o, e.cyc, e.g, e.d, e.dr, e.b, e.t);
                    end
                end
            end
        end
    endtask

    task automatic test_cooldown_drop();
        int c = cyc;
        int tgt = c + 6;
        req_i = 5'b00001; set_len(0, 3);
        push_hang(c, 5'b00001, 3, '0);
        for (int ph = 0; ph < 3; ph++) begin
            while (cyc < tgt) begin
                step();
                while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    e = sb.pop_front(); n_cmp++;
                    if (e.cyc != cyc || grant_o !== e.g || done_o !== e.d || drop_o !== e.dr ||
                        busy_o !== e.b || total_o !== e.t) begin
                        n_err++;
                        $display("FAIL cooldown_drop cyc=%0d got g=%b d=%b dr=%b b=%b t=%h exp cyc=%0d g=%b d=%b dr=%b b=%b t=%h",
                                 cyc, grant_o, done_o, drop_o, busy_o, total_o, e.cyc, e.g, e.d, e.dr, e.b, e.t);
                    end
                end
            end
            if (ph == 0) begin
                req_i = 5'b01000; set_len(3, 5);
                foreach (sb[i]) if (sb[i].cyc == c + 7) sb[i].dr = 5'b01000;
                tgt = c + 3 + COOL + 1;
            end else if (ph == 1) begin
                req_i = 5'b01000; set_len(3, 2);
                push_hang(cyc, 5'b01000, 2, '0);
                tgt = cyc + 2 + COOL + 1;
            end
        end
    endtask

    task automatic test_len_zero();
        int c = cyc;
        int tgt = c + 1;
        req_i = 5'b00010; set_len(1, 0);
        push_rec(c + 1, '0, '0, 5'b00010, 1'b0);
        for (int ph = 0; ph < 2; ph++) begin
            while (cyc < tgt) begin
                step();
                while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    e = sb.pop_front(); n_cmp++;
                    if (e.cyc != cyc || grant_o !== e.g || done_o !== e.d || drop_o !== e.dr ||
                        busy_o !== e.b || total_o !== e.t) begin
                        n_err++;
                        $display("FAIL len_zero cyc=%0d got g=%b d=%b dr=%b b=%b t=%h exp cyc=%0d g=%b d=%b dr=%b b=%b t=%h",
                                 cyc, grant_o, done_o, drop_o, busy_o, total_o, e.cyc, e.g, e.d, e.dr, e.b, e.t);
                    end
                end
            end
            if (ph == 0) begin
                req_i = 5'b00010; set_len(1, 2);
                push_hang(cyc, 5'b00010, 2, '0);
                tgt = cyc + 2 + COOL + 1;
            end
        end
    endtask

    task automatic test_enable_abort();
        int c = cyc;
        int tgt = c + 5;
        req_i = 5'b00100; set_len(2, 1000);
        push_hang(c, 5'b00100, 6, '0);
        for (int ph = 0; ph < 3; ph++) begin
            while (cyc < tgt) begin
                step();
                while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    e = sb.pop_front(); n_cmp++;
                    if (e.cyc != cyc || grant_o !== e.g || done_o !== e.d || drop_o !== e.dr ||
                        busy_o !== e.b || total_o !== e.t) begin
                        n_err++;
                        $display("FAIL enable_abort cyc=%0d got g=%b d=%b dr=%b b=%b t=%h exp cyc=%0d g=%b d=%b dr=%b b=%b t=%h",
                                 cyc, grant_o, done_o, drop_o, busy_o, total_o, e.cyc, e.g, e.d, e.dr, e.b, e.t);
                    end
                end
            end
            if (ph == 0) begin
                enable_i = 1'b0;
                tgt = c + 6 + COOL + 1;
            end else if (ph == 1) begin
                req_i = 5'b00001; set_len(0, 4);
                push_rec(cyc + 1, '0, '0, 5'b00001, 1'b0);
                tgt = cyc + 1;
            end
        end
        enable_i = 1'b1;
    endtask

    task automatic test_reset_mid_hang();
        int c = cyc;
        req_i = 5'b01000; set_len(3, 50);
        exp_total = exp_total + 16'd1;
        for (int k = 1; k <= 3; k++) push_rec(c + k, 5'b01000, '0, '0, 1'b1);
        while (cyc < c + 3) begin
            step();
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front(); n_cmp++;
                if (e.cyc != cyc || grant_o !== e.g || done_o !== e.d || drop_o !== e.dr ||
                    busy_o !== e.b || total_o !== e.t) begin
                    n_err++;
                    $display("FAIL reset_mid_hang cyc=%0d got g=%b d=%b dr=%b b=%b t=%h exp cyc=%0d g=%b d=%b dr=%b b=%b t=%h",
                             cyc, grant_o, done_o, drop_o, busy_o, total_o, e.cyc, e.g, e.d, e.dr, e.b, e.t);
                end
            end
        end
        #2 rst_ni = 1'b0;
        #1;
        exp_total = 16'd0;
        n_cmp++;
        if ({grant_o, done_o, drop_o, busy_o, total_o} !== '0) begin
            n_err++;
            $display("FAIL async_reset got g=%b d=%b dr=%b b=%b t=%h exp all zero",
                     grant_o, done_o, drop_o, busy_o, total_o);
        end
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic test_total_saturate();
        int c;
        while (cyc < START + 1) step();
        force dut.r_total = 16'hFFFF;
        step();
        release dut.r_total;
        exp_total = 16'hFFFF;
        c = cyc;
        req_i = 5'b00001; set_len(0, 2);
        push_hang(c, 5'b00001, 2, '0);
        while (cyc < c + 2 + COOL + 1) begin
            step();
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front(); n_cmp++;
                if (e.cyc != cyc || grant_o !== e.g || done_o !== e.d || drop_o !== e.dr ||
                    busy_o !== e.b || total_o !== e.t) begin
                    n_err++;
                    $display("FAIL total_saturate cyc=%0d got g=%b d=%b dr=%b b=%b t=%h exp cyc=%0d g=%b d=%b dr=%b b=%b t=%h",
                             cyc, grant_o, done_o, drop_o, busy_o, total_o, e.cyc, e.g, e.d, e.dr, e.b, e.t);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_start_window();
        test_single_hang();
        test_round_robin();
        test_cooldown_drop();
        test_len_zero();
        test_enable_abort();
        test_reset_mid_hang();
        test_total_saturate();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover got=%0d entries exp=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
